prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side program loader for the tiny CPU's program-load interface.
- Takes a framed byte stream on a valid/ready port and sequences one-byte writes into the CPU's 16-byte memory: drives load-mode, a 4-bit address and an 8-bit data byte.
- Holds the CPU in reset for the whole frame, then releases it so execution restarts at PC 0.
- Sits between the host link (UART/SPI deserialiser) and the CPU load pins: ui_in[7], ui_in[3:0] and uio_in.

Parameters:
- RST_CYCLES, 4: number of cycles cpu_rst_n stays low after the last frame byte is accepted; range 1..255.
- TIMEOUT, 255: maximum idle cycles between frame bytes before abort; 0 disables the timeout; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- ld_mode  out  1  load strobe, maps to CPU ui_in[7]
- ld_addr  out  4  memory address, maps to CPU ui_in[3:0]
- ld_data  out  8  memory data, maps to CPU uio_in
- cpu_rst_n  out  1  CPU reset, active low
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes successfully
- err  out  1  sticky error flag

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: s_ready=0, ld_mode=0, ld_addr=0, ld_data=0, cpu_rst_n=1, busy=0, done=0, err=0, state=IDLE. All outputs are registered.
- A byte transfers on a rising clk edge when s_valid and s_ready are both 1.
- Frame format:
  - Header byte: [7:4] = start address, [3:0] = count-1, giving 1..16 data bytes.
  - Then count data bytes.
  - Then a checksum byte, chosen so that (sum of data + checksum) mod 256 = 0.
- FSM states: IDLE, DATA, WRITE, CHK, RST, ERR.
- IDLE:
  - s_ready=1.
  - On header accept: store addr and remaining count, clear err, clear the 8-bit sum, drive cpu_rst_n=0, busy=1, go to DATA.
- DATA:
  - s_ready=1.
  - On accept: ld_data<=s_data, ld_addr<=addr, ld_mode<=1, sum<=sum+s_data, go to WRITE.
- WRITE:
  - Exactly one cycle with ld_mode=1 and s_ready=0; this is back-pressure and the host must hold the next byte.
  - Next cycle: ld_mode<=0, addr<=addr+1 (mod 16, so 15 wraps to 0), remaining--.
  - If remaining was 1, go to CHK; otherwise go to DATA.
- ld_addr and ld_data stay stable the whole cycle ld_mode=1. ld_mode is never high outside WRITE, so each data byte produces exactly one memory write.
- CHK:
  - s_ready=1.
  - On accept: if (sum+byte) mod 256 == 0, go to RST; otherwise go to ERR.
- RST:
  - cpu_rst_n=0 for RST_CYCLES cycles, then cpu_rst_n<=1 with it.
  - In that same cycle: done pulses for one cycle, busy<=0, go to IDLE.
- ERR:
  - err<=1, busy<=0, cpu_rst_n stays 0, then go to IDLE.
  - err and the CPU hold persist until the next header is accepted. The next successful frame releases cpu_rst_n at its end.
- Timeout:
  - In DATA or CHK, an idle counter increments each cycle without a transfer and clears on any transfer.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to ERR. Memory bytes already written stay written.
- s_valid while in WRITE, RST or ERR is ignored, because s_ready=0.
- rst_n asserted mid-frame returns all outputs to reset values immediately. ld_mode drops asynchronously, so no partial write occurs after reset.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: the frame carries the checksum byte, the CHK state exists, and a mismatch produces ERR.
- Undefined: no checksum byte; after the last WRITE the FSM goes straight to RST. The sum register and CHK state are removed, and err is set only by timeout.

Test Plan:
- Basic load:
  - Stimulus: header 0x02, data 0x12, 0x05, 0x20, checksum 0xC9.
  - Response: writes addr0=0x12, addr1=0x05, addr2=0x20, each with exactly one ld_mode cycle; cpu_rst_n low from header through RST_CYCLES=4 cycles after the checksum; done pulses once; err=0.
- Address wrap:
  - Stimulus: header 0xE2, data 0xAA, 0xBB, 0xCC, checksum 0xCF.
  - Response: writes addr 14=0xAA, addr 15=0xBB, addr 0=0xCC; done=1.
- Bad checksum:
  - Stimulus: header 0x00, data 0x10, checksum 0x00.
  - Response: addr0 written with 0x10; err=1; no done; cpu_rst_n stays 0.
  - Then a valid frame (header 0x00, data 0x10, checksum 0xF0): err clears, done pulses, cpu_rst_n returns to 1.
- Timeout:
  - Stimulus: header 0x01, one data byte, then s_valid=0 for 255 cycles.
  - Response: err=1 exactly at the 255th idle cycle; busy=0.
- Back-pressure:
  - Stimulus: s_valid held high continuously with a 16-byte frame (header 0x0F).
  - Response: s_ready=0 on every WRITE cycle; 16 writes to addresses 0..15 in order with no byte lost or duplicated.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 while ld_mode=1.
  - Response: ld_mode=0 and cpu_rst_n=1 immediately (asynchronous); state=IDLE after release.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: turns a framed byte stream into one-byte writes to the CPU's
// 16-byte memory, holding the CPU in reset for the frame. Define PROG_LOADER_CHECKSUM_EN to add the checksum byte.
// Latency: one WRITE cycle per data byte; s_ready drops during WRITE, RST and ERR.
module prog_loader #(
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ld_mode,
  output logic [3:0] ld_addr,
  output logic [7:0] ld_data,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    RST,
    ERR
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] addr;
  logic [4:0] remaining;
  logic [7:0] idle_cnt;
  logic [7:0] rst_cnt;
  logic       xfer;
  logic       timeout_hit;

  assign xfer        = s_valid & s_ready;
  assign timeout_hit = (TIMEOUT != 0) && !xfer && (idle_cnt == TO_LAST);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nxt;
  assign sum_nxt = sum + s_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      ld_mode   <= 1'b0;
      ld_addr   <= 4'd0;
      ld_data   <= 8'd0;
      cpu_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr      <= 4'd0;
      remaining <= 5'd0;
      idle_cnt  <= 8'd0;
      rst_cnt   <= 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (xfer) begin
            addr      <= s_data[7:4];
            remaining <= {1'b0, s_data[3:0]} + 5'd1;
            err       <= 1'b0;
            idle_cnt  <= 8'd0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
            state     <= DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            ld_data  <= s_data;
            ld_addr  <= addr;
            ld_mode  <= 1'b1;
            idle_cnt <= 8'd0;
            s_ready  <= 1'b0;
            state    <= WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= sum_nxt;
`endif
          end else if (timeout_hit) begin
            s_ready <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= ERR;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        WRITE: begin
          ld_mode   <= 1'b0;
          addr      <= addr + 4'd1;
          remaining <= remaining - 5'd1;
          if (remaining == 5'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            s_ready <= 1'b1;
            state   <= CHK;
`else
            rst_cnt <= 8'd0;
            state   <= RST;
`endif
          end else begin
            s_ready <= 1'b1;
            state   <= DATA;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            s_ready  <= 1'b0;
            idle_cnt <= 8'd0;
            if (sum_nxt == 8'd0) begin
              rst_cnt <= 8'd0;
              state   <= RST;
            end else begin
              state <= ERR;
            end
          end else if (timeout_hit) begin
            s_ready <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= ERR;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
`endif
        RST: begin
          // Release the CPU and report completion on the same edge.
          if (rst_cnt == RST_LAST) begin
            cpu_rst_n <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            s_ready   <= 1'b1;
            state     <= IDLE;
          end else begin
            rst_cnt <= rst_cnt + 8'd1;
          end
        end
        ERR: begin
          err     <= 1'b1;
          busy    <= 1'b0;
          s_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame table through a write scoreboard, plus timeout and async-reset sequences.
module tb_prog_loader;

  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 255;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0;
  logic       s_ready, ld_mode, cpu_rst_n, busy, done, err;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;

  prog_loader #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ld_mode(ld_mode), .ld_addr(ld_addr), .ld_data(ld_data), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       hdr;
    logic [15:0][7:0] dat;
    logic [7:0]       chk;
    logic             bad;
  } vec_t;

  vec_t        vecs[6];
  logic [11:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so the write monitor sees each cycle exactly once.
  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    if (done) done_cnt++;
    if (rst_n && ld_mode) begin
      check("wr_backpressure", 32'(s_ready), 0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", ld_addr, ld_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr_data", 32'({ld_addr, ld_data}), 32'(e));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 64) begin
      tick();
      n++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles, required acceptance", b, n);
    end else begin
      tick();
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] a;
    int cnt, k, d0;
    a   = v.hdr[7:4];
    cnt = int'(v.hdr[3:0]) + 1;
    d0  = done_cnt;
    send_byte(v.hdr);
    check("hdr_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("hdr_busy", 32'(busy), 1);
    check("hdr_err", 32'(err), 0);
    for (int i = 0; i < cnt; i++) begin
      sb.push_back({a, v.dat[i]});
      a = a + 4'd1;
      send_byte(v.dat[i]);
    end
    if (CHK_EN) send_byte(v.chk);
    s_valid = 1'b0;
    k = 0;
    while (cpu_rst_n == 1'b0 && k < 20) begin
      tick();
      k++;
    end
    if (v.bad) begin
      check("bad_hold_cycles", k, 20);
      check("bad_err", 32'(err), 1);
      check("bad_busy", 32'(busy), 0);
      check("bad_no_done", done_cnt - d0, 0);
    end else begin
      check("rst_low_cycles", k, RST_CYCLES + (CHK_EN ? 0 : 1));
      check("done_at_release", 32'(done), 1);
      tick();
      tick();
      check("done_once", done_cnt - d0, 1);
      check("ok_err", 32'(err), 0);
      check("ok_busy", 32'(busy), 0);
      check("ok_cpu_rst_n", 32'(cpu_rst_n), 1);
    end
    check("sb_drained", sb.size(), 0);
  endtask

  function automatic vec_t mk(input logic [7:0] hdr, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] chk, input logic bad);
    vec_t v;
    v        = '0;
    v.hdr    = hdr;
    v.dat[0] = b0;
    v.dat[1] = b1;
    v.dat[2] = b2;
    v.chk    = chk;
    v.bad    = bad;
    return v;
  endfunction

  initial begin
    logic [7:0] s;
    vecs[0] = mk(8'h02, 8'h12, 8'h05, 8'h20, 8'hC9, 1'b0);
    vecs[1] = mk(8'hE2, 8'hAA, 8'hBB, 8'hCC, 8'hCF, 1'b0);
    vecs[2] = mk(8'h00, 8'h10, 8'h00, 8'h00, 8'h00, CHK_EN);
    vecs[3] = mk(8'h00, 8'h10, 8'h00, 8'h00, 8'hF0, 1'b0);
    vecs[4] = '0;
    vecs[4].hdr = 8'h0F;
    s = 8'd0;
    for (int i = 0; i < 16; i++) begin
      vecs[4].dat[i] = 8'(i * 37 + 1);
      s = s + vecs[4].dat[i];
    end
    vecs[4].chk = 8'd0 - s;
    vecs[5] = mk(8'hA1, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0);

    #12;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_ld_mode", 32'(ld_mode), 0);
    check("rst_ld_addr", 32'(ld_addr), 0);
    check("rst_ld_data", 32'(ld_data), 0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_s_ready", 32'(s_ready), 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Timeout: one byte of a two-byte frame, then silence.
    send_byte(8'h01);
    sb.push_back({4'd0, 8'h5A});
    send_byte(8'h5A);
    s_valid = 1'b0;
    repeat (TIMEOUT) tick();
    check("to_err_before", 32'(err), 0);
    check("to_busy_before", 32'(busy), 1);
    tick();
    check("to_err", 32'(err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_cpu_hold", 32'(cpu_rst_n), 0);
    tick();
    check("to_idle_ready", 32'(s_ready), 1);
    run_vec(vecs[1]);

    // Asynchronous reset while a write strobe is up.
    send_byte(8'h03);
    sb.push_back({4'd0, 8'h77});
    send_byte(8'h77);
    s_valid = 1'b0;
    check("pre_rst_ld_mode", 32'(ld_mode), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ld_mode", 32'(ld_mode), 0);
    check("arst_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("arst_busy", 32'(busy), 0);
    check("arst_s_ready", 32'(s_ready), 0);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(s_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    run_vec(vecs[0]);

    check("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
